mem_responder: RTL and testbench



---
 rtl/mem_responder_pkg.sv | 19 +
 rtl/mem_responder_if.sv | 17 +
 rtl/mem_responder_mem_array.sv | 30 +++
 rtl/mem_responder.sv | 158 +++++++++++++++
 tb/tb_mem_responder.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder and the core-side controller:
// FSM state encoding, mapped-address offsets and wait-counter sizing.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Mapped word addresses, counted down from the top of the address space.
    localparam int unsigned IO_OFFSET  = 0;
    localparam int unsigned CYC_OFFSET = 1;

    function automatic int unsigned cnt_width(input int unsigned wait_cycles);
        return (wait_cycles <= 1) ? 1 : $clog2(wait_cycles);
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Core memory port: single-cycle request strobe with a one-cycle ready response.
interface mem_responder_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;

    modport master (output req, output we, output addr, output wdata,
                    input  rdata, input ready);
    modport slave  (input  req, input we, input addr, input wdata,
                    output rdata, output ready);
endinterface

// File: rtl/mem_responder_mem_array.sv
// Single-port synchronous RAM, write-first: a write also presents the written
// word on the registered read port. Read data holds while en is low.
module mem_array #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 8,
    parameter string       INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_q[addr] <= wdata;
                rdata_q     <= wdata;
            end else begin
                rdata_q     <= mem_q[addr];
            end
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/mem_responder.sv
// Unified instruction/data memory for the multicycle core: programmable wait
// states, one-cycle ready pulse, mapped output port and free-running cycle counter.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter string       INIT_FILE   = ""
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_responder_if.slave       bus,
    output logic [DATA_W-1:0]    io_out,
    output logic                 overrun
);
    localparam int unsigned       CNT_W    = cnt_width(WAIT_CYCLES);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_W-1:0] IO_ADDR  = ADDR_MAX - ADDR_W'(IO_OFFSET);
    localparam logic [ADDR_W-1:0] CYC_ADDR = ADDR_MAX - ADDR_W'(CYC_OFFSET);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] io_q, io_d;
    logic              overrun_q, overrun_d;
    logic [DATA_W-1:0] cyc_q, cyc_d;
    logic              src_ram_q, src_ram_d;
    logic [DATA_W-1:0] reg_rdata_q, reg_rdata_d;

    logic              access;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              ram_en, ram_we;
    logic [DATA_W-1:0] ram_rdata;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        ready_d     = 1'b0;
        io_d        = io_q;
        overrun_d   = overrun_q;
        cyc_d       = cyc_q + DATA_W'(1);
        src_ram_d   = src_ram_q;
        reg_rdata_d = reg_rdata_q;
        access      = 1'b0;
        acc_we      = we_q;
        acc_addr    = addr_q;
        acc_wdata   = wdata_q;
        ram_en      = 1'b0;
        ram_we      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    we_d    = bus.we;
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    if (WAIT_CYCLES == 0) begin
                        // Zero wait states: access uses the live request on the accepting edge.
                        access    = 1'b1;
                        acc_we    = bus.we;
                        acc_addr  = bus.addr;
                        acc_wdata = bus.wdata;
                        state_d   = ST_RESP;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    end
                end
            end
            ST_BUSY: begin
                if (bus.req) overrun_d = 1'b1;
                if (cnt_q == '0) begin
                    access  = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (bus.req) overrun_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (access) begin
            ready_d = 1'b1;
            if (acc_addr == IO_ADDR) begin
                src_ram_d   = 1'b0;
                reg_rdata_d = acc_we ? acc_wdata : io_q;
                if (acc_we) io_d = acc_wdata;
            end else if (acc_addr == CYC_ADDR) begin
                src_ram_d   = 1'b0;
                reg_rdata_d = cyc_q;
            end else begin
                // Reset on the access edge must leave the RAM untouched.
                src_ram_d = 1'b1;
                ram_en    = !reset;
                ram_we    = !reset && acc_we;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ready_q     <= 1'b0;
            io_q        <= '0;
            overrun_q   <= 1'b0;
            cyc_q       <= '0;
            src_ram_q   <= 1'b0;
            reg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ready_q     <= ready_d;
            io_q        <= io_d;
            overrun_q   <= overrun_d;
            cyc_q       <= cyc_d;
            src_ram_q   <= src_ram_d;
            reg_rdata_q <= reg_rdata_d;
        end
    end

    mem_array #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .INIT_FILE(INIT_FILE)
    ) u_mem (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .addr (acc_addr),
        .wdata(acc_wdata),
        .rdata(ram_rdata)
    );

    assign bus.rdata = src_ram_q ? ram_rdata : reg_rdata_q;
    assign bus.ready = ready_q;
    assign io_out    = io_q;
    assign overrun   = overrun_q;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: four instances with WAIT_CYCLES 1, 0, 3, 2,
// a vector table of accesses, a response scoreboard and hand-built corner sequences.
module tb_mem_responder;

    function automatic int unsigned wait_of(input int unsigned idx);
        case (idx)
            0:       return 1;
            1:       return 0;
            2:       return 3;
            default: return 2;
        endcase
    endfunction

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a   [4];
    logic        req_a   [4];
    logic        we_a    [4];
    logic [7:0]  addr_a  [4];
    logic [31:0] wdata_a [4];
    logic [31:0] rdata_a [4];
    logic        ready_a [4];
    logic [31:0] io_a    [4];
    logic        ovr_a   [4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        mem_responder_if #(.DATA_W(32), .ADDR_W(8)) bus ();
        assign bus.req   = req_a[g];
        assign bus.we    = we_a[g];
        assign bus.addr  = addr_a[g];
        assign bus.wdata = wdata_a[g];
        assign rdata_a[g] = bus.rdata;
        assign ready_a[g] = bus.ready;

        mem_responder #(
            .DATA_W     (32),
            .ADDR_W     (8),
            .WAIT_CYCLES(wait_of(g)),
            .INIT_FILE  ("")
        ) u_dut (
            .clk    (clk),
            .reset  (rst_a[g]),
            .bus    (bus),
            .io_out (io_a[g]),
            .overrun(ovr_a[g])
        );
    end

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        int unsigned dut;
        logic [31:0] data;
        logic        chk;
        string       name;
    } sb_t;
    sb_t sb [$];

    // Every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ready_a[i] === 1'b1) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_ready: dut%0d got ready=1 expected no response", i);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    if (e.dut != i || (e.chk && rdata_a[i] !== e.data)) begin
                        n_bad++;
                        $display("FAIL %s: dut%0d rdata got %h expected dut%0d %h",
                                 e.name, i, rdata_a[i], e.dut, e.data);
                    end
                end
            end
        end
    end

    // One access on instance idx; checks ready latency and a single-cycle pulse.
    task automatic access(input int unsigned idx, input logic w, input logic [7:0] a,
                          input logic [31:0] d, input logic [31:0] exp, input logic chk,
                          input string nm, output logic [31:0] rd, output logic [31:0] io);
        int unsigned lat;
        @(posedge clk); #1;
        req_a[idx] = 1'b1; we_a[idx] = w; addr_a[idx] = a; wdata_a[idx] = d;
        sb.push_back('{idx, exp, chk, nm});
        @(posedge clk); #1;
        req_a[idx] = 1'b0;
        lat = 0; rd = '0; io = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (ready_a[idx] === 1'b1) begin
                lat = k; rd = rdata_a[idx]; io = io_a[idx];
                break;
            end
        end
        check({nm, "_latency"}, lat, wait_of(idx) + 1);
        @(negedge clk);
        check({nm, "_ready_drop"}, {31'd0, ready_a[idx]}, 32'd0);
    endtask

    typedef struct {
        int unsigned dut;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;

    initial begin
        vec_t        vecs [13];
        logic [31:0] rd, io, rd1, rd2, ram_max_old, pre3;

        vecs[0]  = '{0, 1'b1, 8'd5,   32'h1234_5678, 32'h1234_5678, "w1_wr5"};
        vecs[1]  = '{0, 1'b0, 8'd5,   32'h0,         32'h1234_5678, "w1_rd5"};
        vecs[2]  = '{1, 1'b1, 8'd7,   32'hDEAD_BEEF, 32'hDEAD_BEEF, "w0_wr7"};
        vecs[3]  = '{1, 1'b0, 8'd7,   32'h0,         32'hDEAD_BEEF, "w0_rd7"};
        vecs[4]  = '{1, 1'b1, 8'd253, 32'hCAFE_F00D, 32'hCAFE_F00D, "w0_wr253"};
        vecs[5]  = '{1, 1'b0, 8'd253, 32'h0,         32'hCAFE_F00D, "w0_rd253"};
        vecs[6]  = '{1, 1'b1, 8'd255, 32'h0000_00A5, 32'h0000_00A5, "w0_wr_io"};
        vecs[7]  = '{1, 1'b0, 8'd255, 32'h0,         32'h0000_00A5, "w0_rd_io"};
        vecs[8]  = '{0, 1'b1, 8'd10,  32'h0F0F_0F0F, 32'h0F0F_0F0F, "w1_wr10"};
        vecs[9]  = '{0, 1'b0, 8'd10,  32'h0,         32'h0F0F_0F0F, "w1_rd10"};
        vecs[10] = '{2, 1'b1, 8'd0,   32'hFFFF_FFFF, 32'hFFFF_FFFF, "w3_wr0"};
        vecs[11] = '{3, 1'b1, 8'd3,   32'h1111_1111, 32'h1111_1111, "w2_wr3"};
        vecs[12] = '{3, 1'b0, 8'd3,   32'h0,         32'h1111_1111, "w2_rd3"};

        for (int i = 0; i < 4; i++) begin
            rst_a[i] = 1'b1; req_a[i] = 1'b0; we_a[i] = 1'b0;
            addr_a[i] = '0; wdata_a[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) rst_a[i] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_ready%0d", i), {31'd0, ready_a[i]}, 32'd0);
            check($sformatf("rst_rdata%0d", i), rdata_a[i], 32'd0);
            check($sformatf("rst_io%0d", i), io_a[i], 32'd0);
            check($sformatf("rst_ovr%0d", i), {31'd0, ovr_a[i]}, 32'd0);
        end

        ram_max_old = g_dut[1].u_dut.u_mem.mem_q[255];

        for (int v = 0; v < 13; v++) begin
            access(vecs[v].dut, vecs[v].we, vecs[v].addr, vecs[v].wdata,
                   vecs[v].exp, 1'b1, vecs[v].name, rd, io);
            if (vecs[v].we && vecs[v].addr == 8'd255)
                check({vecs[v].name, "_io_at_ready"}, io, vecs[v].wdata);
        end
        check("io_hold", io_a[1], 32'h0000_00A5);
        check("io_other_dut", io_a[0], 32'h0);
        check("ram_max_untouched", g_dut[1].u_dut.u_mem.mem_q[255], ram_max_old);
        check("ram_253_backdoor", g_dut[1].u_dut.u_mem.mem_q[253], 32'hCAFE_F00D);

        // Cycle counter: two reads issued exactly 10 cycles apart.
        access(1, 1'b0, 8'd254, 32'h0, 32'h0, 1'b0, "cyc_rd_a", rd1, io);
        repeat (7) @(posedge clk);
        access(1, 1'b0, 8'd254, 32'h0, 32'h0, 1'b0, "cyc_rd_b", rd2, io);
        check("cyc_delta", rd2 - rd1, 32'd10);

        // Overrun on WAIT_CYCLES=3: second req in cycle 2 is dropped.
        @(posedge clk); #1;
        req_a[2] = 1'b1; we_a[2] = 1'b0; addr_a[2] = 8'd0;
        sb.push_back('{2, 32'hFFFF_FFFF, 1'b1, "ovr_first_rd"});
        @(posedge clk); #1; req_a[2] = 1'b0;
        @(negedge clk); check("ovr_c1_ready", {31'd0, ready_a[2]}, 32'd0);
        @(posedge clk); #1;
        req_a[2] = 1'b1; we_a[2] = 1'b1; addr_a[2] = 8'd0; wdata_a[2] = 32'h0;
        @(negedge clk); check("ovr_c2_flag", {31'd0, ovr_a[2]}, 32'd0);
        @(posedge clk); #1; req_a[2] = 1'b0; we_a[2] = 1'b0;
        @(negedge clk);
        check("ovr_c3_flag", {31'd0, ovr_a[2]}, 32'd1);
        check("ovr_c3_ready", {31'd0, ready_a[2]}, 32'd0);
        @(negedge clk); check("ovr_c4_ready", {31'd0, ready_a[2]}, 32'd1);
        @(negedge clk);
        check("ovr_c5_ready", {31'd0, ready_a[2]}, 32'd0);
        check("ovr_c5_flag", {31'd0, ovr_a[2]}, 32'd1);
        access(2, 1'b0, 8'd0, 32'h0, 32'hFFFF_FFFF, 1'b1, "ovr_dropped_write", rd, io);
        check("ovr_sticky", {31'd0, ovr_a[2]}, 32'd1);

        // Reset on the edge that would enter RESP with WAIT_CYCLES=2.
        pre3 = g_dut[3].u_dut.u_mem.mem_q[3];
        @(posedge clk); #1;
        req_a[3] = 1'b1; we_a[3] = 1'b1; addr_a[3] = 8'd3; wdata_a[3] = 32'h55;
        @(posedge clk); #1; req_a[3] = 1'b0; we_a[3] = 1'b0;
        @(posedge clk); #1;
        rst_a[3] = 1'b1; req_a[3] = 1'b1;
        @(posedge clk); #1;
        rst_a[3] = 1'b0; req_a[3] = 1'b0;
        @(negedge clk);
        check("rstmid_ready", {31'd0, ready_a[3]}, 32'd0);
        check("rstmid_rdata", rdata_a[3], 32'd0);
        check("rstmid_io", io_a[3], 32'd0);
        check("rstmid_ovr", {31'd0, ovr_a[3]}, 32'd0);
        repeat (4) @(negedge clk);
        check("rstmid_ram3", g_dut[3].u_dut.u_mem.mem_q[3], pre3);
        access(3, 1'b0, 8'd3, 32'h0, 32'h1111_1111, 1'b1, "rstmid_reread", rd, io);

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

endmodule
